// File: rtl/tm1638_pkg.sv
// tm1638_pkg: TM1638 command bytes, frame layout and driver FSM states.
package tm1638_pkg;
    localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0     = 8'hC0;
    localparam logic [7:0] CMD_DISP_ON   = 8'h88;
    localparam int         FRAME_BYTES   = 19;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    // Frame byte idx: 0x40, 0xC0, display RAM 0x00..0x0F (LED k at odd address 2k+1), display on.
    function automatic logic [7:0] frame_byte(input logic [4:0] idx, input logic [7:0] snap, input logic [2:0] bright);
        return idx == 5'd0  ? CMD_DATA_AUTO :
               idx == 5'd1  ? CMD_ADDR0 :
               idx == 5'd18 ? (CMD_DISP_ON | {5'b0, bright}) :
               idx[0]       ? {7'b0, snap[3'((idx - 5'd3) >> 1)]} : 8'h00;
    endfunction
endpackage

// File: rtl/tm1638_byte_tx.sv
// tm1638_byte_tx: shifts one byte LSB first; tm_clk falls with each new bit, low then high for CLK_DIV cycles.
module tm1638_byte_tx #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tm_clk,
    output logic       tm_dio,
    output logic       done
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic          active;
    logic [CW-1:0] hcnt;
    logic [3:0]    half;
    logic [7:0]    sh;
    logic          hend;

    assign hend = hcnt == CW'(CLK_DIV - 1);
    // Last cycle of the byte, so a following start lands exactly on the next falling edge.
    assign done = active && hend && half == 4'd15;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            active <= 1'b0;
            hcnt   <= '0;
            half   <= '0;
            sh     <= '0;
            tm_clk <= 1'b1;
            tm_dio <= 1'b1;
        end else if (start) begin
            active <= 1'b1;
            hcnt   <= '0;
            half   <= '0;
            sh     <= byte_in;
            tm_clk <= 1'b0;
            tm_dio <= byte_in[0];
        end else if (active) begin
            hcnt <= hend ? '0 : hcnt + 1'b1;
            if (hend) begin
                active <= !done;
                half   <= half + 4'd1;
                tm_clk <= done || !half[0];
                if (done)
                    tm_dio <= 1'b1;
                else if (half[0]) begin
                    sh     <= sh >> 1;
                    tm_dio <= sh[1];
                end
            end
        end
endmodule

// File: rtl/tm1638_led_driver.sv
// tm1638_led_driver: refreshes the TM1638 discrete LEDs from led[7:0] at reset release and on every pattern change.
module tm1638_led_driver
    import tm1638_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int BRIGHTNESS = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] led,
    output logic       tm_stb,
    output logic       tm_clk,
    output logic       tm_dio,
    output logic       busy
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    state_t        state, state_n;
    logic [CW-1:0] hc;
    logic [4:0]    idx;
    logic [7:0]    snap;
    logic          init;
    logic          hc_end, start, done, last_in_tx;
    logic [7:0]    tx_byte;

    assign hc_end     = hc == CW'(CLK_DIV - 1);
    assign last_in_tx = idx == 5'd0 || idx == 5'd17 || idx == 5'd18;
    // In SHIFT the byte loaded on done is the one after idx.
    assign tx_byte    = frame_byte(state == SHIFT ? idx + 5'd1 : idx, snap, 3'(BRIGHTNESS));

    tm1638_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk(clk),
        .reset(reset),
        .start(start),
        .byte_in(tx_byte),
        .tm_clk(tm_clk),
        .tm_dio(tm_dio),
        .done(done)
    );

    always_comb begin
        state_n = state;
        start   = 1'b0;
        case (state)
            IDLE:  state_n = (init || led != snap) ? SETUP : IDLE;
            SETUP: begin
                state_n = hc_end ? SHIFT : SETUP;
                start   = hc_end;
            end
            SHIFT: begin
                state_n = done && last_in_tx ? GAP : SHIFT;
                start   = done && !last_in_tx;
            end
            GAP:   state_n = !hc_end ? GAP : idx == 5'(FRAME_BYTES) ? IDLE : SETUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state  <= IDLE;
            hc     <= '0;
            idx    <= '0;
            snap   <= '0;
            init   <= 1'b1;
            tm_stb <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            tm_stb <= !(state_n == SETUP || state_n == SHIFT);
            busy   <= state_n != IDLE;
            hc     <= (state == SETUP || state == GAP) && !hc_end ? hc + 1'b1 : '0;
            if (state == IDLE && state_n == SETUP) begin
                snap <= led;
                init <= 1'b0;
                idx  <= '0;
            end else if (done)
                idx <= idx + 5'd1;
        end
endmodule

// File: doc/tm1638_led_driver.md
# tm1638_led_driver

Serial output stage for the TM1638 board: consumes the 8-bit LED pattern produced by the pattern generator (`led[7:0]`) and drives the TM1638 STB/CLK/DIO pins so the eight discrete LEDs mirror it. Sits directly downstream of the pattern block, in the same `clk` domain, and is write-only (no key scan). It sends a full refresh frame at reset release and again whenever the input pattern differs from the last pattern sent.

## Interface
- `CLK_DIV`, 50, sys-clock cycles per `tm_clk` half-period (≥2; 50 → 500 kHz at 50 MHz).
- `BRIGHTNESS`, 7, display-control brightness, 0..7, lower 3 bits used.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset.
- `led`  input  8  LED pattern, synchronous to `clk`; bit k drives LED k.
- `tm_stb`  output  1  TM1638 strobe, active low.
- `tm_clk`  output  1  TM1638 serial clock, idles high.
- `tm_dio`  output  1  TM1638 data, always driven.
- `busy`  output  1  high while a frame is in progress.

## Operation
- Frame is 19 bytes in 3 STB transactions:
  - T1 `0x40`: data write, auto-increment.
  - T2 `0xC0`, then 16 data bytes for addresses 0x00..0x0F.
  - T3 `0x88 | BRIGHTNESS[2:0]`: display on.
- T2 data bytes:
  - Even address: `0x00` (7-seg digits blank).
  - Odd address 2k+1: `{7'b0, snap[k]}`.
  - Byte index 3+2k in the frame carries LED k.
- Bytes are sent LSB first.
- `snap` is a register loaded from `led` on the IDLE→SETUP transition. All frame bytes derive from `snap`, never from live `led`.
- Start condition, evaluated in IDLE only:
  - `init` flag is set: it is set by reset and cleared at frame start; or
  - `led != snap`.
- FSM states:
  - IDLE → SETUP: on start condition.
  - SETUP: STB low, clk high, CLK_DIV cycles → SHIFT.
  - SHIFT: 8 bits × 2 half-periods.
  - After last bit of a byte: → SHIFT with the next byte if the transaction continues, else → GAP.
  - GAP: STB high, CLK_DIV cycles.
  - GAP → SETUP for the next transaction, or → IDLE after T3.
- Counters:
  - half-period counter 0..CLK_DIV-1;
  - bit counter 0..7;
  - byte index 0..18.
  - Transaction ends after index 0, 17 and 18.
- `led` changes during a frame do not alter the frame in progress. They are picked up at IDLE by the `led != snap` compare.
- A change that reverts before IDLE causes no extra frame.
- Reset mid-frame:
  - Asserting `reset` returns all outputs to idle values immediately (asynchronous).
  - `init` is set, so a complete frame starting with `0x40` is sent after release.

## Timing
- Reset values: `tm_stb`=1, `tm_clk`=1, `tm_dio`=1, `busy`=0. `snap`=0, `init`=1.
- First frame: STB falls on the first `clk` edge after `reset` deasserts (IDLE→SETUP on that edge).
- `busy` rises with STB on frame start and falls on the cycle the FSM re-enters IDLE.
- Bit cell:
  - `tm_clk` falls, and `tm_dio` updates on that same edge. Low for CLK_DIV cycles.
  - `tm_clk` is then high for CLK_DIV cycles.
  - `tm_dio` is stable across the whole high phase; the TM1638 samples on the rising edge.
- STB rises at the end of the last bit's high phase. It stays high for CLK_DIV cycles (GAP) before the next STB fall.
- Transaction length: CLK_DIV × (2 + 16·n) cycles, where n is the byte count.
- Frame length: 310·CLK_DIV cycles; 1240 at CLK_DIV=4.
- Back-to-back frames: the next SETUP begins 1 cycle after IDLE is entered when the start condition holds.
- `tm_dio` returns to 1 in GAP/IDLE.

## Structure
- Package `tm1638_pkg` holds:
  - `CMD_DATA_AUTO`=8'h40, `CMD_ADDR0`=8'hC0, `CMD_DISP_ON`=8'h88;
  - `FRAME_BYTES`=19;
  - FSM state enum (IDLE, SETUP, SHIFT, GAP).
- One natural sub-module: `tm1638_byte_tx`.
  - Inputs: `start`, `byte_in`, `CLK_DIV`.
  - Outputs: `tm_clk`, `tm_dio`, `done`. Emits one LSB-first byte.
  - Top keeps the frame FSM, STB control, byte-index mux and `snap`/`init`.

## Test plan
Bench uses CLK_DIV=4, BRIGHTNESS=7 and decodes bytes on `tm_clk` rising edges, grouped by STB.
- Reset release, `led`=0x00 → transactions {0x40}, {0xC0, 16×0x00}, {0x8F}; `busy` high exactly 1240 cycles, then IDLE with no further frames.
- `led`=0xA5 from idle → one frame; T2 odd-address bytes (k=0..7) = 01,00,01,00,00,01,00,01; even-address bytes 0x00.
- `led` 0x01→0x03 mid-frame → current frame carries 0x01 pattern; exactly one more frame with 0x03, STB falling 1 cycle after `busy` falls.
- `led` 0x01→0x02→0x01 within a frame sending 0x01 → no second frame.
- `reset` asserted during byte 10 → same cycle `tm_stb`/`tm_clk`/`tm_dio`=1, `busy`=0; after release a full frame starting with 0x40.
- Every bit: `tm_clk` low 4 / high 4 cycles, `tm_dio` constant during high phase; STB high ≥4 cycles between transactions.
